aline_ram_writer: RTL and testbench

//  Avalon-MM write master that drives the single-port 32-bit on-chip sample RAM

---
 rtl/aline_ram_writer_if.sv | 14 +
 rtl/aline_ram_writer.sv | 112 +++++++++++
 tb/tb_aline_ram_writer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aline_ram_writer_if.sv
// Avalon-MM write bus from the A-line writer to the single-port 32-bit sample RAM.
interface aline_ram_writer_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              clken;

  modport master (output address, byteenable, chipselect, write, writedata, clken);
  modport slave  (input  address, byteenable, chipselect, write, writedata, clken);
endinterface

// File: rtl/aline_ram_writer.sv
// Captures one A-line of ADC samples per sweep trigger, packs sample pairs into
// 32-bit words and writes them into a ring of line slots in the sample RAM.
module aline_ram_writer #(
  parameter int ADDR_W     = 15,
  parameter int SAMPLE_W   = 16,
  parameter int LINE_WORDS = 1024,
  parameter int NUM_LINES  = 16,
  parameter int BASE_ADDR  = 0,
  localparam int SLOT_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
  localparam int WORD_W    = $clog2(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                disarm,
  input  logic                sweep_trig,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  aline_ram_writer_if.master  bus,
  output logic                busy,
  output logic                line_done,
  output logic [SLOT_W-1:0]   line_index,
  output logic                overrun
);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SLOT_W-1:0]   slot;
  logic [WORD_W-1:0]   word_cnt;
  logic                half;
  logic [SAMPLE_W-1:0] hold;
  logic                start_line;
  logic                last_write;
  logic                take_sample;
  logic                take_odd;
  logic [ADDR_W-1:0]   wr_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_line  = (state == WAIT_TRIG) && sweep_trig && !disarm;
    last_write  = bus.write && (word_cnt == WORD_W'(LINE_WORDS - 1));
    // The sample arriving during the final write belongs to no line and is dropped.
    take_sample = sample_valid && !disarm &&
                  (start_line || ((state == CAPTURE) && !last_write));
    take_odd    = take_sample && half && (state == CAPTURE);
    busy        = (state != IDLE);
    unique case (state)
      IDLE:      if (arm)        state_nxt = WAIT_TRIG;
      WAIT_TRIG: if (sweep_trig) state_nxt = CAPTURE;
      CAPTURE:   if (last_write) state_nxt = WAIT_TRIG;
      default:                   state_nxt = IDLE;
    endcase
    if (disarm) state_nxt = IDLE;
  end

  assign wr_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(slot) * ADDR_W'(LINE_WORDS) + ADDR_W'(word_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.address    <= '0;
      bus.byteenable <= '0;
      bus.chipselect <= 1'b0;
      bus.write      <= 1'b0;
      bus.writedata  <= '0;
      bus.clken      <= 1'b0;
      line_done      <= 1'b0;
      line_index     <= '0;
      overrun        <= 1'b0;
      slot           <= '0;
      word_cnt       <= '0;
      half           <= 1'b0;
      hold           <= '0;
    end else begin
      bus.clken      <= 1'b1;
      bus.write      <= take_odd;
      bus.chipselect <= take_odd;
      bus.byteenable <= take_odd ? 4'hF : 4'h0;
      line_done      <= 1'b0;
      overrun        <= (state == CAPTURE) && sweep_trig;
      if (take_odd) begin
        bus.address   <= wr_addr;
        bus.writedata <= {sample_data, hold};
      end
      if (take_sample && !take_odd) hold <= sample_data;
      // word_cnt advances after each write, so it always names the word being written.
      if (disarm) begin
        word_cnt <= '0;
        half     <= 1'b0;
      end else if (start_line) begin
        word_cnt <= '0;
        half     <= sample_valid;
      end else if (last_write) begin
        line_done  <= 1'b1;
        line_index <= slot;
        slot       <= (slot == SLOT_W'(NUM_LINES - 1)) ? '0 : slot + 1'b1;
        word_cnt   <= '0;
        half       <= 1'b0;
      end else begin
        if (take_sample) half     <= ~half;
        if (bus.write)   word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aline_ram_writer.sv
// Scoreboard bench for aline_ram_writer: expected RAM writes and line completions
// are queued as samples are driven and checked as the bus produces them.
module tb_aline_ram_writer;
  localparam int ADDR_W     = 15;
  localparam int LINE_WORDS = 1024;
  localparam int NUM_LINES  = 16;
  localparam int BASE_ADDR  = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm = 1'b0;
  logic        disarm = 1'b0;
  logic        sweep_trig = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        busy;
  logic        line_done;
  logic [3:0]  line_index;
  logic        overrun;

  aline_ram_writer_if #(.ADDR_W(ADDR_W)) bus ();

  aline_ram_writer #(
    .ADDR_W(ADDR_W), .SAMPLE_W(16), .LINE_WORDS(LINE_WORDS),
    .NUM_LINES(NUM_LINES), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .disarm(disarm),
    .sweep_trig(sweep_trig), .sample_valid(sample_valid), .sample_data(sample_data),
    .bus(bus), .busy(busy), .line_done(line_done), .line_index(line_index),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_wr_q[$];
  logic [3:0] exp_done_q[$];
  wr_t        mon_exp;
  logic [3:0] mon_idx;
  int vectors = 0, miscompares = 0, cyc = 0;
  int write_count = 0, done_count = 0, overrun_count = 0;
  int first_write_cyc = -1, last_write_cyc = -1, line_start_cyc = 0;
  int m_slot = 0, m_wcnt = 0;
  bit m_half = 1'b0;
  logic [15:0] m_hold = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      vectors++;
      if (bus.write === 1'b1) begin
        write_count++;
        if (write_count == 1) first_write_cyc = cyc;
        last_write_cyc = cyc;
        if (exp_wr_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL write_unexpected got addr=%0h data=%h, required no write", bus.address, bus.writedata);
        end else begin
          mon_exp = exp_wr_q.pop_front();
          if (bus.address !== mon_exp.addr || bus.writedata !== mon_exp.data ||
              bus.byteenable !== 4'hF || bus.chipselect !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL write_beat got addr=%0h data=%h be=%h cs=%b, required addr=%0h data=%h be=f cs=1",
                     bus.address, bus.writedata, bus.byteenable, bus.chipselect, mon_exp.addr, mon_exp.data);
          end
        end
      end else if (bus.chipselect !== 1'b0 || bus.byteenable !== 4'h0) begin
        miscompares++;
        $display("[TB] FAIL idle_bus got cs=%b be=%h, required cs=0 be=0", bus.chipselect, bus.byteenable);
      end
      if (line_done === 1'b1) begin
        done_count++;
        vectors++;
        if (exp_done_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL done_unexpected got line_index=%0d, required no line_done", line_index);
        end else begin
          mon_idx = exp_done_q.pop_front();
          if (line_index !== mon_idx || cyc != last_write_cyc + 1) begin
            miscompares++;
            $display("[TB] FAIL done_beat got index=%0d delay=%0d, required index=%0d delay=1",
                     line_index, cyc - last_write_cyc, mon_idx);
          end
        end
      end
      if (overrun === 1'b1) overrun_count++;
    end
  end

  task automatic model_sample(input logic [15:0] d);
    wr_t w;
    if (!m_half) begin
      m_hold = d;
      m_half = 1'b1;
    end else begin
      w.addr = ADDR_W'(BASE_ADDR + m_slot * LINE_WORDS + m_wcnt);
      w.data = {d, m_hold};
      exp_wr_q.push_back(w);
      m_half = 1'b0;
      m_wcnt++;
      if (m_wcnt == LINE_WORDS) begin
        exp_done_q.push_back(4'(m_slot));
        m_slot = (m_slot + 1) % NUM_LINES;
        m_wcnt = 0;
      end
    end
  endtask

  task automatic drive(input bit a, input bit d, input bit t, input bit v, input logic [15:0] s);
    @(posedge clk);
    #1;
    arm = a; disarm = d; sweep_trig = t; sample_valid = v; sample_data = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic send_line(input logic [15:0] seed, input int overrun_at);
    logic [15:0] s;
    m_half = 1'b0;
    m_wcnt = 0;
    for (int i = 0; i < 2 * LINE_WORDS; i++) begin
      s = seed + 16'(i);
      drive(1'b0, 1'b0, (i == 0) || (i == overrun_at), 1'b1, s);
      if (i == 0) line_start_cyc = cyc;
      model_sample(s);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    arm = 1'b0; disarm = 1'b0; sweep_trig = 1'b0; sample_valid = 1'b0; sample_data = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_wr_q.delete();
    exp_done_q.delete();
    m_slot = 0; m_wcnt = 0; m_half = 1'b0;
    write_count = 0; done_count = 0; overrun_count = 0;
    first_write_cyc = -1; last_write_cyc = -1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("[TB] FAIL %s got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.write, bus.chipselect, bus.byteenable, bus.address, bus.writedata, bus.clken,
         busy, line_done, line_index, overrun} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got wr=%b cs=%b be=%h addr=%h clken=%b busy=%b idx=%0d, required all 0",
               bus.write, bus.chipselect, bus.byteenable, bus.address, bus.clken, busy, line_index);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.clken !== 1'b1 || busy !== 1'b0 || bus.write !== 1'b0 || line_index !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL after_reset got clken=%b busy=%b write=%b idx=%0d, required 1 0 0 0",
               bus.clken, busy, bus.write, line_index);
    end
  endtask

  task automatic test_single_line();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check_int("busy_after_arm", int'(busy), 1);
    send_line(16'h0000, -1);
    idle(4);
    check_int("single_writes", write_count, LINE_WORDS);
    check_int("single_done", done_count, 1);
    check_int("first_write_latency", first_write_cyc - line_start_cyc, 2);
    check_int("single_queue_left", exp_wr_q.size() + exp_done_q.size(), 0);
    check_int("single_overrun", overrun_count, 0);
    check_int("single_busy_wait", int'(busy), 1);
  endtask

  task automatic test_ring_wrap();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int l = 0; l < NUM_LINES + 1; l++) begin
      send_line(16'(l * 4099), -1);
      idle(3);
    end
    check_int("wrap_writes", write_count, (NUM_LINES + 1) * LINE_WORDS);
    check_int("wrap_done", done_count, NUM_LINES + 1);
    check_int("wrap_queue_left", exp_wr_q.size() + exp_done_q.size(), 0);
    check_int("wrap_line_index", int'(line_index), 0);
  endtask

  task automatic test_overrun();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    send_line(16'h1000, 500);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(4);
    check_int("overrun_pulses", overrun_count, 2);
    check_int("overrun_writes", write_count, LINE_WORDS);
    check_int("overrun_done", done_count, 1);
    check_int("overrun_queue_left", exp_wr_q.size() + exp_done_q.size(), 0);
  endtask

  task automatic test_disarm();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    m_half = 1'b0; m_wcnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, i == 0, 1'b1, 16'h2000 + 16'(i));
      model_sample(16'h2000 + 16'(i));
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    idle(3);
    check_int("disarm_writes", write_count, 1);
    check_int("disarm_done", done_count, 0);
    check_int("disarm_busy", int'(busy), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    m_half = 1'b0; m_wcnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, i == 0, 1'b1, 16'h3000 + 16'(i));
      model_sample(16'h3000 + 16'(i));
    end
    idle(3);
    check_int("rearm_writes", write_count, 3);
    check_int("rearm_queue_left", exp_wr_q.size(), 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    idle(2);
  endtask

  task automatic test_wait_drop();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h4000 + 16'(i));
    idle(3);
    check_int("wait_drop_writes", write_count, 0);
    check_int("wait_busy", int'(busy), 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      check_int("arm_disarm_busy", int'(busy), 0);
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, i == 0, 1'b1, 16'h5000 + 16'(i));
    idle(3);
    check_int("idle_drop_writes", write_count, 0);
    check_int("idle_busy", int'(busy), 0);
  endtask

  task automatic test_reset_midwrite();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int l = 0; l < 2; l++) begin
      send_line(16'h6000 + 16'(l * 16), -1);
      idle(3);
    end
    check_int("pre_reset_index", int'(line_index), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h7000);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h7001);
    @(posedge clk);
    #1;
    check_int("midwrite_strobe", int'(bus.write), 1);
    reset_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    vectors++;
    if (bus.write !== 1'b0 || bus.chipselect !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_midwrite got write=%b cs=%b busy=%b, required 0 0 0",
               bus.write, bus.chipselect, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_int("post_reset_index", int'(line_index), 0);
    check_int("post_reset_clken", int'(bus.clken), 1);
  endtask

  initial begin
    $display("[TB] aline_ram_writer bench start");
    test_reset();
    test_single_line();
    test_ring_wrap();
    test_overrun();
    test_disarm();
    test_wait_drop();
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
